// File: rtl/tomasula_types.sv
// Shared instruction-word types for the Tomasulo datapath: station entries and ALU issue words.
package tomasula_types;

  localparam int TAG_W = 3;
  localparam logic [6:0] OP_ARITH = 7'b0110011;

  typedef struct packed {
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             src1_valid;
    logic [TAG_W-1:0] src1_tag;
    logic [31:0]      src1_data;
    logic             src2_valid;
    logic [TAG_W-1:0] src2_tag;
    logic [31:0]      src2_data;
    logic [31:0]      pc;
    logic [TAG_W-1:0] rd_tag;
  } res_word;

  typedef struct packed {
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [31:0]      src1_data;
    logic [31:0]      src2_data;
    logic [31:0]      pc;
    logic [TAG_W-1:0] tag;
  } alu_word;

endpackage

// File: rtl/arith_res_station_if.sv
// Dispatch / CDB / ALU-issue bundle of the arithmetic reservation station.
interface arith_res_station_if #(parameter int NUM_ENTRIES = 4);
  import tomasula_types::*;

  localparam int CNT_W = $clog2(NUM_ENTRIES) + 1;

  logic             flush;
  logic             disp_valid;
  res_word          disp_word;
  logic             rs_full;
  logic [CNT_W-1:0] rs_count;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;
  logic             alu_valid;
  logic             alu_ready;
  alu_word          alu_out;

  modport master (
    output flush, disp_valid, disp_word, cdb_valid, cdb_tag, cdb_value, alu_ready,
    input  rs_full, rs_count, alu_valid, alu_out
  );

  modport slave (
    input  flush, disp_valid, disp_word, cdb_valid, cdb_tag, cdb_value, alu_ready,
    output rs_full, rs_count, alu_valid, alu_out
  );

endinterface

// File: rtl/arith_res_station.sv
// Reservation station: buffers dispatched ops, snoops the CDB for operands and issues
// the lowest-index operand-complete entry to the ALU over valid/ready.
module arith_res_station #(
  parameter int NUM_ENTRIES = 4
) (
  input logic               clk,
  input logic               rst,
  arith_res_station_if.slave rs
);
  import tomasula_types::*;

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  res_word                entries_r [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] busy_r;
  logic [CNT_W-1:0]       count_r;

  logic [NUM_ENTRIES-1:0] ready_s;
  logic [IDX_W-1:0]       sel_idx_s;
  logic [IDX_W-1:0]       free_idx_s;
  logic                   full_s;
  logic                   disp_fire_s;
  logic                   issue_fire_s;
  res_word                disp_byp_s;
  alu_word                alu_out_s;

  // Ready vector plus fixed-priority pick of the issue entry and the dispatch slot
  always_comb begin
    ready_s    = '0;
    sel_idx_s  = '0;
    free_idx_s = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      ready_s[i] = busy_r[i] && entries_r[i].src1_valid && entries_r[i].src2_valid;
    end
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (ready_s[i]) begin
        sel_idx_s = IDX_W'(i);
      end else begin
        sel_idx_s = sel_idx_s;
      end
      if (!busy_r[i]) begin
        free_idx_s = IDX_W'(i);
      end else begin
        free_idx_s = free_idx_s;
      end
    end
  end

  assign full_s       = (count_r == CNT_W'(NUM_ENTRIES));
  assign disp_fire_s  = rs.disp_valid && !full_s;
  assign issue_fire_s = (|ready_s) && rs.alu_ready;

  // A broadcast coinciding with dispatch is folded into the incoming word so it is not lost
  always_comb begin
    disp_byp_s = rs.disp_word;
    if (rs.cdb_valid && !rs.disp_word.src1_valid && (rs.disp_word.src1_tag == rs.cdb_tag)) begin
      disp_byp_s.src1_valid = 1'b1;
      disp_byp_s.src1_data  = rs.cdb_value;
    end else begin
      disp_byp_s.src1_valid = rs.disp_word.src1_valid;
    end
    if (rs.cdb_valid && !rs.disp_word.src2_valid && (rs.disp_word.src2_tag == rs.cdb_tag)) begin
      disp_byp_s.src2_valid = 1'b1;
      disp_byp_s.src2_data  = rs.cdb_value;
    end else begin
      disp_byp_s.src2_valid = rs.disp_word.src2_valid;
    end
  end

  // Issue word, forced to zero when nothing is ready
  always_comb begin
    alu_out_s = '0;
    if (|ready_s) begin
      alu_out_s.op        = entries_r[sel_idx_s].op;
      alu_out_s.funct3    = entries_r[sel_idx_s].funct3;
      alu_out_s.funct7    = entries_r[sel_idx_s].funct7;
      alu_out_s.src1_data = entries_r[sel_idx_s].src1_data;
      alu_out_s.src2_data = entries_r[sel_idx_s].src2_data;
      alu_out_s.pc        = entries_r[sel_idx_s].pc;
      alu_out_s.tag       = entries_r[sel_idx_s].rd_tag;
    end else begin
      alu_out_s = '0;
    end
  end

  // Entry storage: wakeup, issue release and dispatch insert; flush drops everything in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries_r[i] <= '0;
      end
    end else if (rs.flush) begin
      busy_r  <= '0;
      count_r <= '0;
    end else begin
      count_r <= count_r + CNT_W'(disp_fire_s) - CNT_W'(issue_fire_s);
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (busy_r[i] && rs.cdb_valid && !entries_r[i].src1_valid &&
            (entries_r[i].src1_tag == rs.cdb_tag)) begin
          entries_r[i].src1_valid <= 1'b1;
          entries_r[i].src1_data  <= rs.cdb_value;
        end
        if (busy_r[i] && rs.cdb_valid && !entries_r[i].src2_valid &&
            (entries_r[i].src2_tag == rs.cdb_tag)) begin
          entries_r[i].src2_valid <= 1'b1;
          entries_r[i].src2_data  <= rs.cdb_value;
        end
        if (issue_fire_s && (sel_idx_s == IDX_W'(i))) begin
          busy_r[i] <= 1'b0;
        end
        if (disp_fire_s && (free_idx_s == IDX_W'(i))) begin
          busy_r[i]    <= 1'b1;
          entries_r[i] <= disp_byp_s;
        end
      end
    end
  end

  assign rs.rs_full   = full_s;
  assign rs.rs_count  = count_r;
  assign rs.alu_valid = |ready_s;
  assign rs.alu_out   = alu_out_s;

endmodule

// File: tb/tb_arith_res_station.sv
// Directed scoreboard bench for arith_res_station: expected issue words are queued at dispatch
// and compared whenever the station completes a valid/ready handshake.
module tb_arith_res_station;
  import tomasula_types::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  alu_word exp_q[$];
  res_word w, e0, e1, e2;

  arith_res_station_if #(.NUM_ENTRIES(4)) rs_if ();
  arith_res_station #(.NUM_ENTRIES(4)) dut (.clk(clk), .rst(rst), .rs(rs_if));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_word mk_res(input logic [2:0] f3, input logic s1v, input logic [2:0] s1t,
                                     input logic [31:0] s1d, input logic s2v, input logic [2:0] s2t,
                                     input logic [31:0] s2d, input logic [31:0] pc, input logic [2:0] rd);
    res_word r;
    r.op = OP_ARITH; r.funct3 = f3; r.funct7 = {4'b0000, f3};
    r.src1_valid = s1v; r.src1_tag = s1t; r.src1_data = s1d;
    r.src2_valid = s2v; r.src2_tag = s2t; r.src2_data = s2d;
    r.pc = pc; r.rd_tag = rd;
    return r;
  endfunction

  function automatic alu_word mk_alu(input res_word r, input logic [31:0] s1, input logic [31:0] s2);
    alu_word a;
    a.op = r.op; a.funct3 = r.funct3; a.funct7 = r.funct7;
    a.src1_data = s1; a.src2_data = s2; a.pc = r.pc; a.tag = r.rd_tag;
    return a;
  endfunction

  // One clock: score any handshake that completes at the coming edge, then land on the next negedge
  task automatic cyc();
    alu_word e;
    #1;
    if (rs_if.alu_valid && rs_if.alu_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", rs_if.alu_out, '0);
      end else begin
        e = exp_q.pop_front();
        chk("issue_word", rs_if.alu_out, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic disp(input res_word r);
    rs_if.disp_valid = 1'b1;
    rs_if.disp_word  = r;
  endtask

  task automatic cdb(input logic v, input logic [2:0] t, input logic [31:0] val);
    rs_if.cdb_valid = v; rs_if.cdb_tag = t; rs_if.cdb_value = val;
  endtask

  initial begin
    rst = 1'b0;
    rs_if.flush = 1'b0; rs_if.disp_valid = 1'b0; rs_if.disp_word = '0;
    rs_if.alu_ready = 1'b0;
    cdb(1'b0, 3'd0, 32'd0);
    #1;
    chk("rst_count", rs_if.rs_count, 3'd0);
    chk("rst_full", rs_if.rs_full, 1'b0);
    chk("rst_valid", rs_if.alu_valid, 1'b0);
    chk("rst_out", rs_if.alu_out, '0);
    @(negedge clk); rst = 1'b1; @(negedge clk);

    // Both operands ready at dispatch: issues the following cycle
    w = mk_res(3'd0, 1'b1, 3'd0, 32'd5, 1'b1, 3'd0, 32'd7, 32'h100, 3'd2);
    disp(w); rs_if.alu_ready = 1'b1; exp_q.push_back(mk_alu(w, 32'd5, 32'd7));
    chk("t1_pre_valid", rs_if.alu_valid, 1'b0);
    cyc(); rs_if.disp_valid = 1'b0;
    chk("t1_valid", rs_if.alu_valid, 1'b1);
    chk("t1_count", rs_if.rs_count, 3'd1);
    chk("t1_out", rs_if.alu_out, mk_alu(w, 32'd5, 32'd7));
    cyc();
    chk("t1_freed", rs_if.rs_count, 3'd0);
    chk("t1_idle", rs_if.alu_valid, 1'b0);

    // Wakeup three cycles after dispatch
    w = mk_res(3'd1, 1'b0, 3'd4, 32'd0, 1'b1, 3'd0, 32'd3, 32'h104, 3'd3);
    disp(w); exp_q.push_back(mk_alu(w, 32'hDEAD, 32'd3));
    cyc(); rs_if.disp_valid = 1'b0;
    chk("t2_wait0", rs_if.alu_valid, 1'b0); cyc();
    chk("t2_wait1", rs_if.alu_valid, 1'b0); cyc();
    cdb(1'b1, 3'd4, 32'hDEAD);
    chk("t2_wait2", rs_if.alu_valid, 1'b0);
    cyc(); cdb(1'b0, 3'd0, 32'd0);
    chk("t2_woken", rs_if.alu_valid, 1'b1);
    cyc();

    // One broadcast wakes both sources
    w = mk_res(3'd2, 1'b0, 3'd5, 32'd0, 1'b0, 3'd5, 32'd0, 32'h108, 3'd4);
    disp(w); exp_q.push_back(mk_alu(w, 32'h11, 32'h11));
    cyc(); rs_if.disp_valid = 1'b0;
    cdb(1'b1, 3'd5, 32'h11);
    cyc(); cdb(1'b0, 3'd0, 32'd0);
    chk("t2b_woken", rs_if.alu_valid, 1'b1);
    cyc();

    // Broadcast in the dispatch cycle is captured by the bypass
    w = mk_res(3'd3, 1'b1, 3'd0, 32'd8, 1'b0, 3'd1, 32'd0, 32'h10C, 3'd5);
    disp(w); cdb(1'b1, 3'd1, 32'd9); exp_q.push_back(mk_alu(w, 32'd8, 32'd9));
    cyc(); rs_if.disp_valid = 1'b0; cdb(1'b0, 3'd0, 32'd0);
    chk("t3_bypass", rs_if.alu_valid, 1'b1);
    cyc();
    chk("t3_count", rs_if.rs_count, 3'd0);

    // Fill, drop the overflow dispatch, drain in index order
    rs_if.alu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w = mk_res(3'(i), 1'b1, 3'd0, 32'(i * 10 + 1), 1'b1, 3'd0, 32'(i * 10 + 2), 32'(32'h200 + i * 4), 3'(i));
      disp(w); exp_q.push_back(mk_alu(w, 32'(i * 10 + 1), 32'(i * 10 + 2)));
      cyc();
    end
    chk("t4_full", rs_if.rs_full, 1'b1);
    chk("t4_count", rs_if.rs_count, 3'd4);
    disp(mk_res(3'd7, 1'b1, 3'd0, 32'd99, 1'b1, 3'd0, 32'd98, 32'h2F0, 3'd7));
    cyc(); rs_if.disp_valid = 1'b0;
    chk("t4_drop_count", rs_if.rs_count, 3'd4);
    rs_if.alu_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain_valid", rs_if.alu_valid, 1'b1);
      cyc();
    end
    chk("t4_empty", rs_if.rs_count, 3'd0);
    chk("t4_idle", rs_if.alu_valid, 1'b0);

    // Entries 0 and 2 ready, entry 1 waiting: hold stability and priority
    rs_if.alu_ready = 1'b0;
    e0 = mk_res(3'd1, 1'b1, 3'd0, 32'h40, 1'b1, 3'd0, 32'h41, 32'h300, 3'd4);
    e1 = mk_res(3'd2, 1'b0, 3'd6, 32'h0,  1'b1, 3'd0, 32'h51, 32'h304, 3'd5);
    e2 = mk_res(3'd3, 1'b1, 3'd0, 32'h60, 1'b1, 3'd0, 32'h61, 32'h308, 3'd6);
    disp(e0); cyc(); disp(e1); cyc(); disp(e2); cyc(); rs_if.disp_valid = 1'b0;
    exp_q.push_back(mk_alu(e0, 32'h40, 32'h41));
    exp_q.push_back(mk_alu(e2, 32'h60, 32'h61));
    cdb(1'b1, 3'd7, 32'h77);
    for (int i = 0; i < 3; i++) begin
      chk("t5_hold", rs_if.alu_out, mk_alu(e0, 32'h40, 32'h41));
      cyc();
    end
    cdb(1'b0, 3'd0, 32'd0);
    rs_if.alu_ready = 1'b1;
    cyc(); cyc();
    chk("t5_e1_waiting", rs_if.alu_valid, 1'b0);
    chk("t5_count", rs_if.rs_count, 3'd1);
    cdb(1'b1, 3'd6, 32'h66); exp_q.push_back(mk_alu(e1, 32'h66, 32'h51));
    cyc(); cdb(1'b0, 3'd0, 32'd0);
    cyc();
    chk("t5_empty", rs_if.rs_count, 3'd0);

    // Dispatch and issue in the same cycle keep the count steady
    w = mk_res(3'd4, 1'b1, 3'd0, 32'h70, 1'b1, 3'd0, 32'h71, 32'h400, 3'd1);
    disp(w); exp_q.push_back(mk_alu(w, 32'h70, 32'h71)); cyc();
    w = mk_res(3'd5, 1'b1, 3'd0, 32'h80, 1'b1, 3'd0, 32'h81, 32'h404, 3'd2);
    disp(w); exp_q.push_back(mk_alu(w, 32'h80, 32'h81)); cyc();
    rs_if.disp_valid = 1'b0;
    chk("t7_count", rs_if.rs_count, 3'd1);
    cyc();
    chk("t7_empty", rs_if.rs_count, 3'd0);

    // Flush a full station with a dispatch and broadcast pending
    rs_if.alu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(mk_res(3'd0, 1'b0, 3'd3, 32'd0, 1'b1, 3'd0, 32'(i), 32'(32'h500 + i * 4), 3'(i)));
      cyc();
    end
    chk("t6_full", rs_if.rs_count, 3'd4);
    rs_if.flush = 1'b1; cdb(1'b1, 3'd3, 32'h33);
    cyc();
    rs_if.flush = 1'b0; rs_if.disp_valid = 1'b0; cdb(1'b0, 3'd0, 32'd0);
    chk("t6_flush_count", rs_if.rs_count, 3'd0);
    chk("t6_flush_valid", rs_if.alu_valid, 1'b0);
    chk("t6_flush_full", rs_if.rs_full, 1'b0);

    // Asynchronous reset while a handshake is being offered
    disp(mk_res(3'd6, 1'b1, 3'd0, 32'h90, 1'b1, 3'd0, 32'h91, 32'h600, 3'd3));
    cyc(); rs_if.disp_valid = 1'b0;
    chk("t6_ready_before_rst", rs_if.alu_valid, 1'b1);
    rs_if.alu_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_valid", rs_if.alu_valid, 1'b0);
    chk("t6_rst_count", rs_if.rs_count, 3'd0);
    chk("t6_rst_out", rs_if.alu_out, '0);
    @(negedge clk); rst = 1'b1; rs_if.alu_ready = 1'b0;
    @(negedge clk);

    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
